// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int WORD_BYTES = 4;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int LAT_CNT_W  = 4;

endpackage

// File: rtl/dmem_responder_mem_array.sv
// Word storage: synchronous write, combinational read by word index, no reset.
// One shared index serves both ports because the responder only ever touches one word per transaction.
module mem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clock,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, then issues a one-cycle response.
// req_ready is high only in IDLE; responses cannot be backpressured.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [LAT_CNT_W-1:0] LAT_INIT =
      (LATENCY == 0) ? '0 : LAT_CNT_W'(LATENCY - 1);

   state_e                 state_q, state_d;
   logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   wr_q;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      wdata_q, rdata_q;
   logic                   err_q;

   logic                   accept, commit;
   logic                   eff_write, eff_err;
   logic [ADDR_W-1:0]      eff_addr;
   logic [DATA_W-1:0]      eff_wdata, mem_rdata;
   logic [IDX_W-1:0]       eff_idx;

   assign accept = req_valid && (state_q == IDLE);

   // With zero latency the commit happens on the accepting edge, so the live request is used.
   assign eff_write = (state_q == IDLE) ? req_write : wr_q;
   assign eff_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign eff_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign eff_idx   = eff_addr[2 +: IDX_W];
   assign eff_err   = (eff_addr[1:0] != 2'b00) || (|eff_addr[ADDR_W-1:IDX_W+2]);
   assign commit    = (state_d == RESP) && (state_q != RESP) && !Reset;

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (LATENCY == 0) ? RESP : BUSY;
               cnt_d   = LAT_INIT;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - LAT_CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = (state_q == RESP);
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (commit) begin
            err_q   <= eff_err;
            rdata_q <= (eff_write || eff_err) ? '0 : mem_rdata;
         end
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_mem (
      .clock   (clock),
      .we_i    (commit && eff_write && !eff_err),
      .idx_i   (eff_idx),
      .wdata_i (eff_wdata),
      .rdata_o (mem_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance against a timestamp/array model.
module tb_dmem_responder;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        req_ready  [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   int vectors = 0;
   int errors  = 0;
   bit chk     = 1'b0;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
      .clock(clock), .Reset(rst[0]),
      .req_valid(req_valid[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
      .clock(clock), .Reset(rst[1]),
      .req_valid(req_valid[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   function automatic int lat(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [inst %0d]: got %h, expected %h", nm, i, act, exp);
      end
   endtask

   // Model: a request accepted in cycle c responds in cycle c+1+LAT and frees the port from c+2+LAT.
   int unsigned cyc = 0;
   int unsigned free_at [2] = '{0, 0};
   int unsigned resp_at [2];
   bit          pend    [2] = '{0, 0};
   logic        p_w     [2];
   logic [31:0] p_a     [2];
   logic [31:0] p_d     [2];
   logic [31:0] mem_m   [2][256];
   logic        e_rdy   [2];
   logic        e_vld   [2];
   logic        e_err   [2];
   logic [31:0] e_rdata [2];

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            pend[i]    = 1'b0;
            e_vld[i]   = 1'b0;
            e_rdata[i] = 32'h0;
            e_err[i]   = 1'b0;
            free_at[i] = cyc + 1;
         end else begin
            e_vld[i] = 1'b0;
            if (req_valid[i] && cyc >= free_at[i]) begin
               pend[i]    = 1'b1;
               p_w[i]     = req_write[i];
               p_a[i]     = req_addr[i];
               p_d[i]     = req_wdata[i];
               resp_at[i] = cyc + 1 + lat(i);
               free_at[i] = cyc + 2 + lat(i);
            end
            if (pend[i] && resp_at[i] == cyc + 1) begin
               pend[i]  = 1'b0;
               e_vld[i] = 1'b1;
               if (p_a[i][1:0] != 2'b00 || p_a[i] >= 32'd1024) begin
                  e_err[i]   = 1'b1;
                  e_rdata[i] = 32'h0;
               end else begin
                  e_err[i] = 1'b0;
                  if (p_w[i]) begin
                     mem_m[i][p_a[i][9:2]] = p_d[i];
                     e_rdata[i] = 32'h0;
                  end else begin
                     e_rdata[i] = mem_m[i][p_a[i][9:2]];
                  end
               end
            end
         end
      end
      cyc++;
      for (int i = 0; i < 2; i++) e_rdy[i] = (cyc >= free_at[i]);
   end

   always @(negedge clock) begin
      if (chk) begin
         for (int i = 0; i < 2; i++) begin
            check("req_ready",  i, 32'(req_ready[i]),  32'(e_rdy[i]));
            check("resp_valid", i, 32'(resp_valid[i]), 32'(e_vld[i]));
            check("resp_rdata", i, resp_rdata[i],      e_rdata[i]);
            check("resp_err",   i, 32'(resp_err[i]),   32'(e_err[i]));
         end
      end
   end

   task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      int k = 0;
      @(negedge clock);
      while (!req_ready[i] && k < 50) begin
         @(negedge clock);
         k++;
      end
      check("ready_before_issue", i, 32'(req_ready[i]), 32'h1);
      req_valid[i] = 1'b1;
      req_write[i] = w;
      req_addr[i]  = a;
      req_wdata[i] = d;
      @(negedge clock);
      req_valid[i] = 1'b0;
      req_write[i] = 1'($urandom);
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
   endtask

   task automatic expect_resp(input int i, input string nm, input logic [31:0] rd,
                              input logic er, input int lat_exp);
      int k = 0;
      while (!resp_valid[i] && k < 50) begin
         @(negedge clock);
         k++;
      end
      check({nm, "_vld"},   i, 32'(resp_valid[i]), 32'h1);
      check({nm, "_lat"},   i, 32'(k),             32'(lat_exp));
      check({nm, "_rdata"}, i, resp_rdata[i],      rd);
      check({nm, "_err"},   i, 32'(resp_err[i]),   32'(er));
      @(negedge clock);
      check({nm, "_1cyc"},  i, 32'(resp_valid[i]), 32'h0);
   endtask

   // Hold req_valid high for ncyc cycles; the address is scrambled whenever the port is busy.
   task automatic stream(input int i, input logic [31:0] a, input int ncyc, output int acc);
      int k = 0;
      acc = 0;
      @(negedge clock);
      while (!req_ready[i] && k < 50) begin
         @(negedge clock);
         k++;
      end
      for (int c = 0; c < ncyc; c++) begin
         req_valid[i] = 1'b1;
         if (req_ready[i]) begin
            req_write[i] = 1'b0;
            req_addr[i]  = a;
            acc++;
         end else begin
            req_write[i] = 1'($urandom);
            req_addr[i]  = $urandom & 32'h0000_03FC;
            req_wdata[i] = $urandom;
         end
         @(negedge clock);
      end
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      repeat (5) @(negedge clock);
   endtask

   initial begin
      int acc;
      for (int i = 0; i < 2; i++) begin
         rst[i]       = 1'b1;
         req_valid[i] = 1'b0;
         req_write[i] = 1'b0;
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'h0;
      end
      repeat (3) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         check("rst_ready", i, 32'(req_ready[i]),  32'h1);
         check("rst_vld",   i, 32'(resp_valid[i]), 32'h0);
         check("rst_rdata", i, resp_rdata[i],      32'h0);
         check("rst_err",   i, 32'(resp_err[i]),   32'h0);
         rst[i] = 1'b0;
      end
      chk = 1'b1;

      // Store then load, LATENCY=2
      issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      expect_resp(0, "st10", 32'h0, 1'b0, 2);
      issue(0, 1'b0, 32'h10, 32'h0);
      expect_resp(0, "ld10", 32'hDEAD_BEEF, 1'b0, 2);

      // Continuous valid: one acceptance every 4 cycles
      stream(0, 32'h10, 12, acc);
      check("stream_accepts", 0, 32'(acc), 32'd3);

      // Error cases
      issue(0, 1'b1, 32'h0, 32'h1111_1111);
      expect_resp(0, "st0", 32'h0, 1'b0, 2);
      issue(0, 1'b0, 32'h12, 32'h0);
      expect_resp(0, "ld_misal", 32'h0, 1'b1, 2);
      issue(0, 1'b1, 32'h400, 32'h0BAD_0BAD);
      expect_resp(0, "st_oor", 32'h0, 1'b1, 2);
      issue(0, 1'b0, 32'h0, 32'h0);
      expect_resp(0, "ld0_after_oor", 32'h1111_1111, 1'b0, 2);
      issue(0, 1'b0, 32'h8000_0000, 32'h0);
      expect_resp(0, "ld_highbit", 32'h0, 1'b1, 2);

      // Reset mid-transaction drops the store and clears the outputs
      issue(0, 1'b1, 32'h20, 32'hCAFE_F00D);
      expect_resp(0, "st20", 32'h0, 1'b0, 2);
      issue(0, 1'b0, 32'h12, 32'h0);
      expect_resp(0, "ld_misal2", 32'h0, 1'b1, 2);
      issue(0, 1'b1, 32'h20, 32'h1234_5678);
      rst[0] = 1'b1;
      @(negedge clock);
      rst[0] = 1'b0;
      check("abort_ready", 0, 32'(req_ready[0]),  32'h1);
      check("abort_vld",   0, 32'(resp_valid[0]), 32'h0);
      check("abort_rdata", 0, resp_rdata[0],      32'h0);
      check("abort_err",   0, 32'(resp_err[0]),   32'h0);
      repeat (4) begin
         @(negedge clock);
         check("abort_no_resp", 0, 32'(resp_valid[0]), 32'h0);
      end
      issue(0, 1'b0, 32'h20, 32'h0);
      expect_resp(0, "ld20_after_abort", 32'hCAFE_F00D, 1'b0, 2);

      // Top word of the array
      issue(0, 1'b1, 32'h3FC, 32'hA5A5_5A5A);
      expect_resp(0, "st3fc", 32'h0, 1'b0, 2);
      issue(0, 1'b0, 32'h3FC, 32'h0);
      expect_resp(0, "ld3fc", 32'hA5A5_5A5A, 1'b0, 2);
      issue(0, 1'b0, 32'h0, 32'h0);
      expect_resp(0, "ld0_after_top", 32'h1111_1111, 1'b0, 2);

      // LATENCY=0 instance
      issue(1, 1'b1, 32'h8, 32'h0BAD_F00D);
      expect_resp(1, "l0_st8", 32'h0, 1'b0, 0);
      issue(1, 1'b0, 32'h8, 32'h0);
      expect_resp(1, "l0_ld8", 32'h0BAD_F00D, 1'b0, 0);
      issue(1, 1'b0, 32'h6, 32'h0);
      expect_resp(1, "l0_misal", 32'h0, 1'b1, 0);
      stream(1, 32'h8, 8, acc);
      check("l0_stream_accepts", 1, 32'(acc), 32'd4);

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
